// File: rtl/demux4_rr_sched.sv
// demux4_rr_sched
//
// Round-robin scheduler that feeds one valid/ready input stream to four sinks
// through a 1-to-4 demux. Each sink receives a burst of BURST_LEN beats, and then
// the scheduler moves on to the next sink. If the selected sink keeps its ready
// low for TIMEOUT consecutive cycles while a beat is pending, the scheduler skips
// that sink. This keeps one dead consumer from blocking the stream.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous reset, active-high
//   en         scheduler enable; 0 pauses (state machine drops to IDLE)
//   in_data    input beat
//   in_valid   input beat valid
//   in_ready   input beat accepted this cycle
//   out_data   in_data broadcast to all sinks
//   out_valid  per-sink valid, bit i = sink i
//   out_ready  per-sink ready; only the selected bit is used
//   sel        current sink index
//   beat_cnt   beats already sent to sel in the current burst
//   skip       one-cycle pulse after a sink has been skipped by timeout

module demux4_rr_sched #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned BURST_LEN  = 4,
    parameter int unsigned TIMEOUT    = 8
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             en,
    input  logic [DATA_WIDTH-1:0]            in_data,
    input  logic                             in_valid,
    output logic                             in_ready,
    output logic [DATA_WIDTH-1:0]            out_data,
    output logic [3:0]                       out_valid,
    input  logic [3:0]                       out_ready,
    output logic [1:0]                       sel,
    output logic [$clog2(BURST_LEN+1)-1:0]   beat_cnt,
    output logic                             skip
);

    localparam int unsigned BcW = $clog2(BURST_LEN + 1);
    // wait_cnt only needs to count 0..TIMEOUT-1. When TIMEOUT=0 it is never
    // compared, so it is allowed to wrap.
    localparam int unsigned WcW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    localparam logic [BcW-1:0] LastBeat = BcW'(BURST_LEN - 1);
    localparam logic [WcW-1:0] LastWait = (TIMEOUT == 0) ? '0 : WcW'(TIMEOUT - 1);

    typedef enum logic [0:0] {
        StIdle,
        StSend
    } state_e;

    state_e         state_q, state_d;
    logic [1:0]     sel_q, sel_d;
    logic [BcW-1:0] beat_cnt_q, beat_cnt_d;
    logic [WcW-1:0] wait_cnt_q, wait_cnt_d;
    logic           skip_q, skip_d;

    logic           sending;
    logic           xfer;

    // Routing is purely combinational: nothing in the data path is stored.
    assign sending  = (state_q == StSend) && en;
    assign in_ready = sending && out_ready[sel_q];
    assign xfer     = in_valid && in_ready;
    assign out_data = in_data;

    always_comb begin
        out_valid = '0;
        for (int i = 0; i < 4; i++) begin
            out_valid[i] = sending && in_valid && (sel_q == 2'(i));
        end
    end

    always_comb begin
        state_d    = state_q;
        sel_d      = sel_q;
        beat_cnt_d = beat_cnt_q;
        wait_cnt_d = wait_cnt_q;
        skip_d     = 1'b0;

        unique case (state_q)
            StIdle: begin
                wait_cnt_d = '0;
                if (en) begin
                    state_d = StSend;
                end
            end
            StSend: begin
                if (!en) begin
                    // Pause mid-burst: sel and beat_cnt hold, so the burst
                    // resumes on the same sink when en returns.
                    state_d    = StIdle;
                    wait_cnt_d = '0;
                end else if (xfer) begin
                    wait_cnt_d = '0;
                    if (beat_cnt_q == LastBeat) begin
                        sel_d      = sel_q + 2'd1;
                        beat_cnt_d = '0;
                    end else begin
                        beat_cnt_d = beat_cnt_q + BcW'(1);
                    end
                end else if (in_valid) begin
                    // Stall: a beat is pending but the selected sink is not ready.
                    if ((TIMEOUT != 0) && (wait_cnt_q == LastWait)) begin
                        sel_d      = sel_q + 2'd1;
                        beat_cnt_d = '0;
                        wait_cnt_d = '0;
                        skip_d     = 1'b1;
                    end else begin
                        wait_cnt_d = wait_cnt_q + WcW'(1);
                    end
                end else begin
                    wait_cnt_d = '0;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            sel_q      <= '0;
            beat_cnt_q <= '0;
            wait_cnt_q <= '0;
            skip_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            sel_q      <= sel_d;
            beat_cnt_q <= beat_cnt_d;
            wait_cnt_q <= wait_cnt_d;
            skip_q     <= skip_d;
        end
    end

    assign sel      = sel_q;
    assign beat_cnt = beat_cnt_q;
    assign skip     = skip_q;

endmodule
